// File: rtl/sifive_scope_pkg.sv
// Shared types for the scope capture sequencer: FSM state encoding and timestamp width.
// Timestamp storage is enabled by defining SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN.
package sifive_scope_pkg;

   localparam int TS_W = 16;

   localparam logic [1:0] ST_ENC_IDLE  = 2'd0;
   localparam logic [1:0] ST_ENC_ARMED = 2'd1;
   localparam logic [1:0] ST_ENC_POST  = 2'd2;
   localparam logic [1:0] ST_ENC_DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_ENC_IDLE,
      ST_ARMED = ST_ENC_ARMED,
      ST_POST  = ST_ENC_POST,
      ST_DONE  = ST_ENC_DONE
   } scope_state_e;

endpackage

// File: rtl/sifive_scope_sample_ram.sv
// Circular sample storage for the scope capture sequencer: one synchronous write port,
// one asynchronous read port. Contents are not reset; the controller tracks validity.
module sifive_scope_sample_ram #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sifive_scope_capture_ctrl.sv
// Scope trigger/capture sequencer: pre-trigger history, post-trigger collection, oldest-first drain.
// Define SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN to store a 16-bit cycle stamp with every sample.
module sifive_scope_capture_ctrl
   import sifive_scope_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_arm,
   input  logic              cfg_abort,
   input  logic [DATA_W-1:0] cfg_trig_mask,
   input  logic [DATA_W-1:0] cfg_trig_value,
   input  logic [CNT_W-1:0]  cfg_post_cnt,
   input  logic              tap_valid,
   input  logic              tap_clk_en,
   input  logic [DATA_W-1:0] tap_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
`ifdef SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN
   output logic [TS_W-1:0]   rd_timestamp,
`endif
   output logic [1:0]        state_o,
   output logic              triggered,
   output logic              overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
`ifdef SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN
   localparam int WORD_W = DATA_W + TS_W;
`else
   localparam int WORD_W = DATA_W;
`endif

   scope_state_e      state;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic [CNT_W-1:0]  post_rem;

   logic              sample;
   logic              hit;
   logic              capturing;
   logic              wr_en;
   logic              full;
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word;

   assign sample    = tap_valid & tap_clk_en;
   assign hit       = sample & ((tap_data & cfg_trig_mask) == (cfg_trig_value & cfg_trig_mask));
   assign capturing = (state == ST_ARMED) || (state == ST_POST);
   assign wr_en     = capturing & sample & ~cfg_abort;
   assign full      = (count == CW'(DEPTH));

`ifdef SIFIVE_SCOPE_CAPTURE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + TS_W'(1);
   end

   assign wr_word      = {ts_cnt, tap_data};
   assign rd_timestamp = rd_valid ? rd_word[DATA_W +: TS_W] : '0;
`else
   assign wr_word = tap_data;
`endif

   sifive_scope_sample_ram #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clock   (clock),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_word),
      .rd_addr (rd_ptr),
      .rd_data (rd_word)
   );

   // Stored-sample bookkeeping is shared by ARMED and POST; the case only handles transitions.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         post_rem  <= '0;
         triggered <= 1'b0;
         overflow  <= 1'b0;
      end else if (cfg_abort) begin
         state    <= ST_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         post_rem <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (full) begin
               rd_ptr   <= rd_ptr + AW'(1);
               overflow <= 1'b1;
            end else begin
               count <= count + CW'(1);
            end
         end

         case (state)
            ST_IDLE: begin
               if (cfg_arm) begin
                  state     <= ST_ARMED;
                  wr_ptr    <= '0;
                  rd_ptr    <= '0;
                  count     <= '0;
                  post_rem  <= '0;
                  triggered <= 1'b0;
                  overflow  <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (hit) begin
                  triggered <= 1'b1;
                  post_rem  <= cfg_post_cnt;
                  state     <= (cfg_post_cnt == '0) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               if (sample) begin
                  post_rem <= (post_rem == '0) ? '0 : post_rem - CNT_W'(1);
                  if (post_rem <= CNT_W'(1)) state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (count == '0) begin
                  state <= ST_IDLE;
               end else if (rd_ready) begin
                  rd_ptr <= rd_ptr + AW'(1);
                  count  <= count - CW'(1);
                  if (count == CW'(1)) state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rd_valid = (state == ST_DONE) && (count != '0);
   assign rd_data  = rd_valid ? rd_word[DATA_W-1:0] : '0;
   assign state_o  = state;

endmodule
